signed_or_unsigned_mul: RTL and testbench

SIGNED_OR_UNSIGNED_MUL -- requirements
Module: signed_or_unsigned_mul

---
 rtl/signed_or_unsigned_mul_pkg.sv | 18 +
 rtl/signed_or_unsigned_mul_pp_row.sv | 50 +++++
 rtl/signed_or_unsigned_mul_ref.sv | 27 ++
 rtl/signed_or_unsigned_mul.sv | 68 ++++++
 tb/tb_signed_or_unsigned_mul.sv | 129 ++++++++++++
 5 files changed

// File: rtl/signed_or_unsigned_mul_pkg.sv
// Purpose : shared types and limits for the signed/unsigned multiplier.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: operand-mode encoding used by the signed_mul select, and the
// supported operand-width range.
package signed_or_unsigned_mul_pkg;

  // Interpretation of the operands, driven by the signed_mul input.
  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

endpackage

// File: rtl/signed_or_unsigned_mul_pp_row.sv
// Purpose : one partial-product row of the multiplier folded into a carry-save pair.
// Latency : combinational, zero cycles.
// Backpressure: none; no handshake.
//
// Ports:
//   a          - multiplicand, n bits
//   b_bit      - the multiplier bit that selects this row
//   signed_mul - 1 = two's-complement operands (Baugh-Wooley inversion applied)
//   sum_in/carry_in   - incoming carry-save pair, 2n bits each
//   sum_out/carry_out - outgoing carry-save pair with this row added
module pp_row
  import signed_or_unsigned_mul_pkg::*;
#(
  parameter int n   = 4,
  parameter int row = 0
) (
  input  logic [n-1:0]   a,
  input  logic           b_bit,
  input  logic           signed_mul,
  input  logic [2*n-1:0] sum_in,
  input  logic [2*n-1:0] carry_in,
  output logic [2*n-1:0] sum_out,
  output logic [2*n-1:0] carry_out
);

  logic [n-1:0]   pp;
  logic [2*n-1:0] pp_ext;
  logic [2*n-2:0] maj;

  // In signed mode the cross terms that pair exactly one sign bit with a
  // magnitude bit carry negative weight; Baugh-Wooley inverts them here and
  // the top adds the matching constant correction.
  always_comb begin
    pp = '0;
    for (int j = 0; j < n; j++) begin
      pp[j] = (a[j] & b_bit) ^
              ((signed_mul == MODE_SIGNED) && ((j == n - 1) != (row == n - 1)));
    end
  end

  assign pp_ext = {{n{1'b0}}, pp} << row;

  // 3:2 compression; the carry out of the top bit falls off (mod 2^(2n)).
  assign sum_out   = sum_in ^ carry_in ^ pp_ext;
  assign maj       = (sum_in[2*n-2:0] & carry_in[2*n-2:0]) |
                     (sum_in[2*n-2:0] & pp_ext[2*n-2:0])   |
                     (carry_in[2*n-2:0] & pp_ext[2*n-2:0]);
  assign carry_out = {maj, 1'b0};

endmodule

// File: rtl/signed_or_unsigned_mul_ref.sv
// Purpose : golden reference products for checking the multiplier.
// Latency : combinational, zero cycles.
// Backpressure: none.
//
// unsigned_mul : res = a * b, operands unsigned, n-bit in, 2n-bit out
// signed_mul_4 : res = a * b, 4-bit two's-complement in, 8-bit signed out
module unsigned_mul #(
  parameter int n = 4
) (
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  output logic [2*n-1:0] res
);
  assign res = {{n{1'b0}}, a} * {{n{1'b0}}, b};
endmodule

module signed_mul_4 (
  input  logic signed [3:0] a,
  input  logic signed [3:0] b,
  output logic signed [7:0] res
);
  logic signed [7:0] ax;
  logic signed [7:0] bx;
  assign ax  = {{4{a[3]}}, a};
  assign bx  = {{4{b[3]}}, b};
  assign res = ax * bx;
endmodule

// File: rtl/signed_or_unsigned_mul.sv
// Purpose : n x n multiplier, unsigned or two's-complement chosen per cycle.
// Latency : res combinational (0 cycles); res_q registered (1 cycle).
// Backpressure: none; every cycle is an independent operation.
//
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset, clears res_q only
//   a, b       - n-bit operands
//   signed_mul - 1 = two's complement, 0 = unsigned
//   res        - 2n-bit combinational product
//   res_q      - res registered on every rising clk edge
module signed_or_unsigned_mul
  import signed_or_unsigned_mul_pkg::*;
#(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [n-1:0]   a,
  input  logic [n-1:0]   b,
  input  logic           signed_mul,
  output logic [2*n-1:0] res,
  output logic [2*n-1:0] res_q
);

  logic [2*n-1:0] corr;
  logic [2*n-1:0] sum_chain   [n+1];
  logic [2*n-1:0] carry_chain [n+1];

  // Baugh-Wooley constant: inverting the negative cross terms leaves a
  // residual of 2^n + 2^(2n-1) (mod 2^(2n)). Seeding it into the sum vector
  // costs no extra adder row.
  always_comb begin
    corr = '0;
    if (signed_mul == MODE_SIGNED) begin
      corr[n]     = 1'b1;
      corr[2*n-1] = 1'b1;
    end
  end

  assign sum_chain[0]   = corr;
  assign carry_chain[0] = '0;

  // One shared partial-product array for both modes.
  for (genvar i = 0; i < n; i++) begin : g_row
    pp_row #(
      .n   (n),
      .row (i)
    ) u_pp_row (
      .a          (a),
      .b_bit      (b[i]),
      .signed_mul (signed_mul),
      .sum_in     (sum_chain[i]),
      .carry_in   (carry_chain[i]),
      .sum_out    (sum_chain[i+1]),
      .carry_out  (carry_chain[i+1])
    );
  end

  // Final carry-propagate adder resolves the carry-save pair.
  assign res = sum_chain[n] + carry_chain[n];

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else     res_q <= res;
  end

endmodule

// File: tb/tb_signed_or_unsigned_mul.sv
module tb_signed_or_unsigned_mul;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   a;
  logic [N-1:0]   b;
  logic           signed_mul;
  logic [2*N-1:0] res;
  logic [2*N-1:0] res_q;
  logic [2*N-1:0] ures;
  logic [2*N-1:0] sres;

  int n_checks = 0;
  int n_fail   = 0;

  signed_or_unsigned_mul #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .signed_mul (signed_mul),
    .res        (res),
    .res_q      (res_q)
  );

  unsigned_mul #(.n(N)) u_ref_u (.a(a), .b(b), .res(ures));
  signed_mul_4          u_ref_s (.a(a), .b(b), .res(sres));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [2*N-1:0] obs, input logic [2*N-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Directed vectors: {signed_mul, a, b, expected product}
  typedef struct packed {
    logic           s;
    logic [N-1:0]   va;
    logic [N-1:0]   vb;
    logic [2*N-1:0] exp;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1'b1, 4'h8, 4'h8, 8'h40}; // -8 * -8 = 64
    vecs[1] = '{1'b1, 4'h8, 4'h7, 8'hC8}; // -8 * 7 = -56
    vecs[2] = '{1'b1, 4'hF, 4'hF, 8'h01}; // -1 * -1 = 1
    vecs[3] = '{1'b0, 4'hF, 4'hF, 8'hE1}; // 15 * 15 = 225
    vecs[4] = '{1'b0, 4'h9, 4'h3, 8'h1B}; // 9 * 3 = 27
    vecs[5] = '{1'b1, 4'hD, 4'h5, 8'hF1}; // -3 * 5 = -15
    vecs[6] = '{1'b0, 4'h0, 4'hF, 8'h00};
    vecs[7] = '{1'b1, 4'hF, 4'h0, 8'h00};
    vecs[8] = '{1'b1, 4'h0, 4'h8, 8'h00};
    vecs[9] = '{1'b0, 4'h7, 4'h0, 8'h00};

    // Reset for two edges, with the combinational path exercised meanwhile.
    rst = 1'b1; a = 4'h3; b = 4'h5; signed_mul = 1'b0;
    @(posedge clk); #1;
    check("comb_live_in_reset", res, 8'h0F);
    @(posedge clk); #1;
    check("res_q_reset", res_q, 8'h00);

    // First edge after reset drop loads the current product: 7 * -2 = -14.
    @(negedge clk);
    rst = 1'b0; a = 4'h7; b = 4'hE; signed_mul = 1'b1;
    #1 check("res_7x-2", res, 8'hF2);
    @(posedge clk); #1;
    check("res_q_after_reset", res_q, 8'hF2);

    // Directed boundary vectors, combinational then registered.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      signed_mul = vecs[k].s; a = vecs[k].va; b = vecs[k].vb;
      #1 check($sformatf("res_vec%0d", k), res, vecs[k].exp);
      @(posedge clk); #1;
      check($sformatf("res_q_vec%0d", k), res_q, vecs[k].exp);
    end

    // Mode toggle with operands held.
    @(negedge clk);
    a = 4'hF; b = 4'hF; signed_mul = 1'b0;
    #1 check("toggle_unsigned", res, 8'hE1);
    signed_mul = 1'b1;
    #1 check("toggle_signed", res, 8'h01);

    // Exhaustive sweeps against the reference models.
    signed_mul = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = i[N-1:0]; b = j[N-1:0];
        #1 check($sformatf("unsigned_%0dx%0d", i, j), res, ures);
      end
    end
    signed_mul = 1'b1;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        a = i[N-1:0]; b = j[N-1:0];
        #1 check($sformatf("signed_%0dx%0d", i, j), res, sres);
      end
    end

    // Reset mid-stream discards the registered value, res stays live.
    @(negedge clk);
    a = 4'h8; b = 4'h8; signed_mul = 1'b1; rst = 1'b0;
    @(posedge clk); #1;
    check("res_q_hold_40", res_q, 8'h40);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("res_q_mid_reset", res_q, 8'h00);
    check("res_during_mid_reset", res, 8'h40);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("res_q_reload", res_q, 8'h40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
